// File: rtl/gpll_reconfig_seq_if.sv
// APB write/read channel between the GPLL reconfiguration sequencer (master) and the PLL wrapper (slave).
interface gpll_reconfig_seq_if;
   logic [4:0]  apb_addr;
   logic        apb_sel;
   logic        apb_en;
   logic        apb_write;
   logic [15:0] apb_wdata;
   logic [15:0] apb_rdata;
   logic        apb_ready;

   modport master (output apb_addr, apb_sel, apb_en, apb_write, apb_wdata,
                   input  apb_rdata, apb_ready);
   modport slave  (input  apb_addr, apb_sel, apb_en, apb_write, apb_wdata,
                   output apb_rdata, apb_ready);
endinterface

// File: rtl/gpll_reconfig_seq.sv
// APB reconfiguration sequencer for the GTP_GPLL: replays a preset profile with the PLL held in reset,
// then qualifies lock with a stability filter, timeout and retries. Macro GPLL_RECONFIG_READBACK_EN adds read-back verify.
module gpll_reconfig_seq #(
   parameter int unsigned NUM_PROFILES       = 4,
   parameter int unsigned NUM_WRITES         = 8,
   parameter logic [NUM_PROFILES*NUM_WRITES*21-1:0] PROFILE_TABLE = '0,
   parameter int unsigned RST_HOLD_CYCLES    = 16,
   parameter int unsigned LOCK_STABLE_CYCLES = 64,
   parameter int unsigned LOCK_TIMEOUT       = 65535,
   parameter int unsigned MAX_RETRY          = 2,
   parameter int unsigned SEL_W              = 2
) (
   input  logic               apb_clk,
   input  logic               apb_rst_n,
   input  logic               cfg_req,
   input  logic [SEL_W-1:0]   cfg_sel,
   output logic               cfg_busy,
   output logic               cfg_done,
   output logic               cfg_err,
   output logic [SEL_W-1:0]   cur_profile,
   output logic               lock_lost,
   input  logic               pll_lock,
   output logic               pll_rst,
   gpll_reconfig_seq_if.master apb
);
   localparam int unsigned ENT_W = 21;
   localparam int unsigned TBL_W = NUM_PROFILES * NUM_WRITES * ENT_W;
   localparam int unsigned BIT_W = $clog2(TBL_W);
   localparam int unsigned CNT_W = $clog2(RST_HOLD_CYCLES + 1);
   localparam int unsigned STB_W = $clog2(LOCK_STABLE_CYCLES + 1);
   localparam int unsigned TMO_W = $clog2(LOCK_TIMEOUT + 1);
   localparam int unsigned RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   localparam int unsigned IDX_W = (NUM_WRITES > 1) ? $clog2(NUM_WRITES) : 1;

   typedef enum logic [2:0] {IDLE, RST_PRE, SETUP, ACCESS, RST_POST, WAIT_LOCK, DONE, ERROR} state_e;

   state_e             state_q, state_n;
   logic [CNT_W-1:0]   cnt_q, cnt_n;
   logic [IDX_W-1:0]   idx_q, idx_n, idx_nxt;
   logic [RTY_W-1:0]   rty_q, rty_n;
   logic [STB_W-1:0]   stb_q, stb_n;
   logic [TMO_W-1:0]   tmo_q, tmo_n;
   logic [SEL_W-1:0]   prof_q, prof_n, cur_n;
   logic               lock_meta, lock_s;
   logic               pll_rst_n, busy_n, done_n, err_n, lost_n;
   logic [4:0]         addr_q, addr_n;
   logic [15:0]        wdata_q, wdata_n;
   logic               sel_q, sel_n, en_q, en_n, wr_q, wr_n;
   logic [ENT_W-1:0]   ent_cur, ent_nxt;
   logic [BIT_W-1:0]   bit_cur, bit_nxt;
   logic               rd_bad;

`ifdef GPLL_RECONFIG_READBACK_EN
   localparam bit READBACK = 1'b1;
   assign rd_bad = (apb.apb_rdata != wdata_q);
`else
   localparam bit READBACK = 1'b0;
   logic unused_rdata;
   assign rd_bad       = 1'b0;
   assign unused_rdata = ^apb.apb_rdata;
`endif

   assign apb.apb_addr  = addr_q;
   assign apb.apb_sel   = sel_q;
   assign apb.apb_en    = en_q;
   assign apb.apb_write = wr_q;
   assign apb.apb_wdata = wdata_q;

   // Table lookup for the current entry and the one the next back-to-back transfer will use.
   always_comb begin
      idx_nxt = (idx_q < IDX_W'(NUM_WRITES - 1)) ? idx_q + IDX_W'(1) : idx_q;
      bit_cur = BIT_W'(ENT_W * (32'(prof_q) * NUM_WRITES + 32'(idx_q)));
      bit_nxt = BIT_W'(ENT_W * (32'(prof_q) * NUM_WRITES + 32'(idx_nxt)));
      ent_cur = PROFILE_TABLE[bit_cur +: ENT_W];
      ent_nxt = PROFILE_TABLE[bit_nxt +: ENT_W];
   end

   always_comb begin
      state_n   = state_q;
      cnt_n     = cnt_q;
      idx_n     = idx_q;
      rty_n     = rty_q;
      stb_n     = stb_q;
      tmo_n     = tmo_q;
      prof_n    = prof_q;
      pll_rst_n = pll_rst;
      busy_n    = cfg_busy;
      done_n    = 1'b0;
      err_n     = cfg_err;
      cur_n     = cur_profile;
      lost_n    = lock_lost;
      addr_n    = addr_q;
      wdata_n   = wdata_q;
      sel_n     = sel_q;
      en_n      = en_q;
      wr_n      = wr_q;
      case (state_q)
         IDLE, DONE, ERROR: begin
            if (state_q == DONE && !lock_s) lost_n = 1'b1;
            if (cfg_req) begin
               if (32'(cfg_sel) >= NUM_PROFILES) begin
                  state_n = ERROR;
                  err_n   = 1'b1;
               end else begin
                  state_n   = RST_PRE;
                  prof_n    = cfg_sel;
                  idx_n     = '0;
                  rty_n     = '0;
                  cnt_n     = '0;
                  err_n     = 1'b0;
                  lost_n    = 1'b0;
                  busy_n    = 1'b1;
                  pll_rst_n = 1'b1;
               end
            end
         end
         RST_PRE: begin
            cnt_n = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(RST_HOLD_CYCLES - 1)) begin
               state_n = SETUP;
               cnt_n   = '0;
               sel_n   = 1'b1;
               en_n    = 1'b0;
               wr_n    = 1'b1;
               addr_n  = ent_cur[20:16];
               wdata_n = ent_cur[15:0];
            end
         end
         SETUP: begin
            state_n = ACCESS;
            en_n    = 1'b1;
         end
         ACCESS: begin
            if (apb.apb_ready) begin
               en_n = 1'b0;
               if (READBACK && wr_q) begin
                  state_n = SETUP;
                  wr_n    = 1'b0;
               end else if (READBACK && rd_bad) begin
                  // Read-back mismatch aborts without retry and frees the PLL
                  state_n   = ERROR;
                  sel_n     = 1'b0;
                  addr_n    = '0;
                  wdata_n   = '0;
                  pll_rst_n = 1'b0;
                  err_n     = 1'b1;
                  busy_n    = 1'b0;
               end else if (idx_q < IDX_W'(NUM_WRITES - 1)) begin
                  state_n = SETUP;
                  idx_n   = idx_nxt;
                  wr_n    = 1'b1;
                  addr_n  = ent_nxt[20:16];
                  wdata_n = ent_nxt[15:0];
               end else begin
                  state_n = RST_POST;
                  sel_n   = 1'b0;
                  wr_n    = 1'b0;
                  addr_n  = '0;
                  wdata_n = '0;
                  cnt_n   = '0;
               end
            end
         end
         RST_POST: begin
            cnt_n = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(RST_HOLD_CYCLES - 1)) begin
               state_n   = WAIT_LOCK;
               cnt_n     = '0;
               stb_n     = '0;
               tmo_n     = '0;
               pll_rst_n = 1'b0;
            end
         end
         WAIT_LOCK: begin
            tmo_n = tmo_q + TMO_W'(1);
            stb_n = lock_s ? stb_q + STB_W'(1) : '0;
            // Timeout wins over a lock qualifying on the same cycle
            if (tmo_q == TMO_W'(LOCK_TIMEOUT - 1)) begin
               stb_n = '0;
               tmo_n = '0;
               if (rty_q < RTY_W'(MAX_RETRY)) begin
                  state_n   = RST_PRE;
                  rty_n     = rty_q + RTY_W'(1);
                  idx_n     = '0;
                  cnt_n     = '0;
                  pll_rst_n = 1'b1;
               end else begin
                  state_n = ERROR;
                  err_n   = 1'b1;
                  busy_n  = 1'b0;
               end
            end else if (lock_s && stb_q == STB_W'(LOCK_STABLE_CYCLES - 1)) begin
               state_n = DONE;
               stb_n   = '0;
               tmo_n   = '0;
               done_n  = 1'b1;
               cur_n   = prof_q;
               busy_n  = 1'b0;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge apb_clk or negedge apb_rst_n) begin
      if (!apb_rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         idx_q       <= '0;
         rty_q       <= '0;
         stb_q       <= '0;
         tmo_q       <= '0;
         prof_q      <= '0;
         lock_meta   <= 1'b0;
         lock_s      <= 1'b0;
         pll_rst     <= 1'b0;
         cfg_busy    <= 1'b0;
         cfg_done    <= 1'b0;
         cfg_err     <= 1'b0;
         cur_profile <= '0;
         lock_lost   <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         sel_q       <= 1'b0;
         en_q        <= 1'b0;
         wr_q        <= 1'b0;
      end else begin
         state_q     <= state_n;
         cnt_q       <= cnt_n;
         idx_q       <= idx_n;
         rty_q       <= rty_n;
         stb_q       <= stb_n;
         tmo_q       <= tmo_n;
         prof_q      <= prof_n;
         lock_meta   <= pll_lock;
         lock_s      <= lock_meta;
         pll_rst     <= pll_rst_n;
         cfg_busy    <= busy_n;
         cfg_done    <= done_n;
         cfg_err     <= err_n;
         cur_profile <= cur_n;
         lock_lost   <= lost_n;
         addr_q      <= addr_n;
         wdata_q     <= wdata_n;
         sel_q       <= sel_n;
         en_q        <= en_n;
         wr_q        <= wr_n;
      end
   end
endmodule

// File: tb/tb_gpll_reconfig_seq.sv
// Scoreboard bench for gpll_reconfig_seq: expected APB transfers and completion events are queued by the
// stimulus thread and popped by a negedge monitor.
module tb_gpll_reconfig_seq;
   localparam int unsigned NP = 4;
   localparam int unsigned NW = 8;
   localparam int unsigned SW = 3;
   localparam int unsigned TBL_W = NP * NW * 21;

   // Profile p, write w: addr = p*8+w, data = 0xA000 + p*0x100 + w*0x11
   function automatic logic [20:0] ent(input int p, input int w);
      logic [4:0]  a;
      logic [15:0] d;
      a = 5'(p * 8 + w);
      d = 16'(32'hA000 + p * 32'h100 + w * 32'h11);
      return {a, d};
   endfunction

   function automatic logic [TBL_W-1:0] mk_table();
      logic [TBL_W-1:0] t;
      t = '0;
      for (int p = 0; p < int'(NP); p++)
         for (int w = 0; w < int'(NW); w++)
            t[21*(p*8+w) +: 21] = ent(p, w);
      return t;
   endfunction

   localparam logic [TBL_W-1:0] TABLE = mk_table();

   typedef struct packed {logic wr; logic [4:0] addr; logic [15:0] data;} apb_t;
   typedef struct packed {logic is_err; logic [2:0] prof;} evt_t;

   logic          clk, rst_n, cfg_req, cfg_busy, cfg_done, cfg_err, lock_lost, pll_lock, pll_rst;
   logic [SW-1:0] cfg_sel, cur_profile;
   logic [15:0]   mem [32];

   gpll_reconfig_seq_if bus ();

   gpll_reconfig_seq #(
      .NUM_PROFILES(NP), .NUM_WRITES(NW), .PROFILE_TABLE(TABLE), .RST_HOLD_CYCLES(16),
      .LOCK_STABLE_CYCLES(64), .LOCK_TIMEOUT(200), .MAX_RETRY(2), .SEL_W(SW)
   ) dut (
      .apb_clk(clk), .apb_rst_n(rst_n), .cfg_req(cfg_req), .cfg_sel(cfg_sel), .cfg_busy(cfg_busy),
      .cfg_done(cfg_done), .cfg_err(cfg_err), .cur_profile(cur_profile), .lock_lost(lock_lost),
      .pll_lock(pll_lock), .pll_rst(pll_rst), .apb(bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   n_chk = 0, n_err = 0;
   apb_t exp_apb[$];
   evt_t exp_evt[$];
   int   len_log[$];
   int   run = 0, pre_run = 0, post_run = 0, acc_len = 0, n_wr = 0, done_cnt = 0, wait_cnt = 0;
   bit   rst_seen = 0, err_q = 0, stall_on = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   assign bus.apb_rdata = mem[bus.apb_addr];

   // Slave: ready immediately, or after 3 wait cycles on write index 4 when stalling
   always @(posedge clk) begin
      #1;
      if (bus.apb_sel && bus.apb_en) begin
         if (stall_on && n_wr == 4 && wait_cnt < 3) begin
            bus.apb_ready = 1'b0;
            wait_cnt++;
         end else bus.apb_ready = 1'b1;
      end else begin
         bus.apb_ready = 1'b0;
         wait_cnt      = 0;
      end
   end

   // Monitor: APB transfers, reset-hold run lengths and completion events
   always @(negedge clk) begin
      evt_t e;
      if (!rst_n) begin
         run     = 0;
         acc_len = 0;
         err_q   = 1'b0;
      end else begin
         if (pll_rst) rst_seen = 1'b1;
         if (pll_rst && !bus.apb_sel) run++;
         else begin
            if (run > 0) begin
               if (bus.apb_sel) pre_run = run;
               else post_run = run;
            end
            run = 0;
         end
         if (bus.apb_sel) begin
            if (exp_apb.size() > 0)
               chk("apb_fields", 32'({bus.apb_write, bus.apb_addr, bus.apb_wdata}), 32'(exp_apb[0]));
            if (bus.apb_en) begin
               acc_len++;
               if (bus.apb_ready) begin
                  if (exp_apb.size() == 0) begin
                     n_chk++;
                     n_err++;
                     $display("FAIL apb_unexpected actual=%0h required=none", bus.apb_addr);
                  end else void'(exp_apb.pop_front());
                  if (bus.apb_write) begin
                     mem[bus.apb_addr] = bus.apb_wdata;
                     n_wr++;
                     len_log.push_back(acc_len);
                  end
                  acc_len = 0;
               end
            end
         end
         if (cfg_done) begin
            done_cnt++;
            if (exp_evt.size() == 0) begin
               n_chk++;
               n_err++;
               $display("FAIL done_unexpected actual=1 required=0");
            end else begin
               e = exp_evt.pop_front();
               chk("done_kind", 32'(e.is_err), 32'(0));
               chk("done_profile", 32'(cur_profile), 32'(e.prof));
               chk("done_busy", 32'(cfg_busy), 32'(0));
            end
         end
         if (cfg_err && !err_q) begin
            if (exp_evt.size() == 0) begin
               n_chk++;
               n_err++;
               $display("FAIL err_unexpected actual=1 required=0");
            end else begin
               e = exp_evt.pop_front();
               chk("err_kind", 32'(e.is_err), 32'(1));
               chk("err_busy", 32'(cfg_busy), 32'(0));
               chk("err_pll_rst", 32'(pll_rst), 32'(0));
            end
         end
         err_q = cfg_err;
      end
   end

   task automatic push_profile(input int p);
      for (int w = 0; w < int'(NW); w++) begin
         exp_apb.push_back({1'b1, ent(p, w)});
`ifdef GPLL_RECONFIG_READBACK_EN
         exp_apb.push_back({1'b0, ent(p, w)});
`endif
      end
   endtask

   task automatic issue(input int s);
      @(posedge clk);
      #1;
      cfg_sel = SW'(s);
      cfg_req = 1'b1;
      @(posedge clk);
      #1;
      cfg_req = 1'b0;
   endtask

   task automatic wait_idle(input string name, input int budget);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while ((cfg_busy || exp_evt.size() != 0) && n < budget);
      if (cfg_busy || exp_evt.size() != 0) begin
         n_chk++;
         n_err++;
         $display("FAIL %s actual=timeout_%0d_cycles required=idle", name, n);
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic wait_fall(input string name);
      int  n;
      bit  hi;
      n  = 0;
      hi = pll_rst;
      do begin
         @(negedge clk);
         n++;
         if (pll_rst) hi = 1'b1;
      end while (!(hi && !pll_rst) && n < 2000);
      if (!(hi && !pll_rst)) begin
         n_chk++;
         n_err++;
         $display("FAIL %s actual=no_pll_rst_fall required=fall", name);
      end
   endtask

   task automatic lock_after(input int cyc);
      repeat (cyc) @(posedge clk);
      #1;
      pll_lock = 1'b1;
   endtask

   initial begin
      int n;
      for (int i = 0; i < 32; i++) mem[i] = '0;
      rst_n = 1'b0; cfg_req = 1'b0; cfg_sel = '0; pll_lock = 1'b0; bus.apb_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_pll_rst", 32'(pll_rst), 0);
      chk("rst_busy", 32'(cfg_busy), 0);
      chk("rst_done", 32'(cfg_done), 0);
      chk("rst_err", 32'(cfg_err), 0);
      chk("rst_lock_lost", 32'(lock_lost), 0);
      chk("rst_cur_profile", 32'(cur_profile), 0);
      chk("rst_apb", 32'({bus.apb_sel, bus.apb_en, bus.apb_write, bus.apb_addr, bus.apb_wdata}), 0);
      rst_n = 1'b1;

      // Nominal programming of profile 1
      n_wr = 0; done_cnt = 0; pre_run = 0; post_run = 0;
      push_profile(1);
      exp_evt.push_back('{is_err: 1'b0, prof: 3'd1});
      issue(1);
      wait_fall("t1_rst_fall");
      lock_after(10);
      wait_idle("t1_idle", 500);
      chk("t1_pre_hold", 32'(pre_run), 16);
      chk("t1_post_hold", 32'(post_run), 16);
      chk("t1_writes", 32'(n_wr), 8);
      chk("t1_done_pulses", 32'(done_cnt), 1);
      chk("t1_cur_profile", 32'(cur_profile), 1);

      // Stalled write 4 plus an ignored request during ACCESS
      pll_lock = 1'b0; n_wr = 0; len_log.delete(); stall_on = 1'b1;
      push_profile(2);
      exp_evt.push_back('{is_err: 1'b0, prof: 3'd2});
      issue(2);
      n = 0;
      do begin @(negedge clk); n++; end while (!(bus.apb_sel && bus.apb_en) && n < 100);
      chk("t2_access_seen", 32'(bus.apb_sel && bus.apb_en), 1);
      issue(3);
      wait_fall("t2_rst_fall");
      lock_after(10);
      wait_idle("t2_idle", 500);
      stall_on = 1'b0;
      chk("t2_writes", 32'(n_wr), 8);
      chk("t2_log_size", 32'(len_log.size()), 8);
      if (len_log.size() > 4) begin
         chk("t2_access_len_w3", 32'(len_log[3]), 1);
         chk("t2_access_len_w4", 32'(len_log[4]), 4);
      end
      chk("t2_cur_profile", 32'(cur_profile), 2);

      // Single-cycle lock drop in DONE
      chk("t3_lost_before", 32'(lock_lost), 0);
      @(posedge clk); #1 pll_lock = 1'b0;
      @(posedge clk); #1 pll_lock = 1'b1;
      repeat (4) @(negedge clk);
      chk("t3_lost_set", 32'(lock_lost), 1);
      repeat (10) @(negedge clk);
      chk("t3_lost_sticky", 32'(lock_lost), 1);

      // Lock glitch restarts the stable filter
      pll_lock = 1'b0;
      push_profile(3);
      exp_evt.push_back('{is_err: 1'b0, prof: 3'd3});
      issue(3);
      @(negedge clk);
      chk("t4_lost_cleared", 32'(lock_lost), 0);
      chk("t4_busy", 32'(cfg_busy), 1);
      wait_fall("t4_rst_fall");
      lock_after(1);
      repeat (32) @(posedge clk);
      #1 pll_lock = 1'b0;
      @(posedge clk);
      #1 pll_lock = 1'b1;
      n = 0;
      do begin @(posedge clk); #1; n++; end while (!cfg_done && n < 300);
      chk("t4_glitch_latency", 32'(n), 66);
      wait_idle("t4_idle", 100);

      // Out-of-range profile select
      rst_seen = 1'b0; n_wr = 0;
      exp_evt.push_back('{is_err: 1'b1, prof: 3'd0});
      issue(5);
      @(negedge clk);
      chk("t5_err", 32'(cfg_err), 1);
      chk("t5_busy", 32'(cfg_busy), 0);
      repeat (20) @(negedge clk);
      chk("t5_no_rst", 32'(rst_seen), 0);
      chk("t5_no_apb", 32'(n_wr), 0);
      chk("t5_cur_profile", 32'(cur_profile), 3);

      // Lock never asserts: three full replays then ERROR
      pll_lock = 1'b0; n_wr = 0;
      for (int r = 0; r < 3; r++) push_profile(0);
      exp_evt.push_back('{is_err: 1'b1, prof: 3'd0});
      issue(0);
      wait_idle("t6_idle", 3000);
      chk("t6_writes", 32'(n_wr), 24);
      chk("t6_err", 32'(cfg_err), 1);
      chk("t6_busy", 32'(cfg_busy), 0);
      chk("t6_pll_rst", 32'(pll_rst), 0);

      // Reset asserted during RST_POST
      push_profile(1);
      issue(1);
      @(negedge clk);
      chk("t7_err_cleared", 32'(cfg_err), 0);
      n = 0;
      do begin @(negedge clk); n++; end
      while (!(exp_apb.size() == 0 && pll_rst && !bus.apb_sel) && n < 500);
      chk("t7_in_rst_post", 32'(pll_rst && !bus.apb_sel), 1);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("t7_pll_rst", 32'(pll_rst), 0);
      chk("t7_apb", 32'({bus.apb_sel, bus.apb_en, bus.apb_write, bus.apb_addr, bus.apb_wdata}), 0);
      chk("t7_busy", 32'(cfg_busy), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      chk("apb_queue_left", 32'(exp_apb.size()), 0);
      chk("evt_queue_left", 32'(exp_evt.size()), 0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
